// File: rtl/pwm_deadtime_inserter.sv
// Complementary half-bridge gate drive with programmable dead time, enable
// and a latching fault shutdown. All decisions use the registered PWM input.
module pwm_deadtime_inserter #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clear,
  output logic                hs_out,
  output logic                ls_out,
  output logic                dt_active,
  output logic                fault_latched
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DT_TO_HS,
    S_HS_ON,
    S_DT_TO_LS,
    S_LS_ON,
    S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DT_WIDTH-1:0] dt_load;
  logic                pwm_q;

  // A programmed dead time of zero still gives one dead cycle.
  assign dt_load = (dead_time == '0) ? '0 : dead_time - DT_WIDTH'(1);

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault) begin
      state_d = S_FAULT;
    end else if (state_q == S_FAULT) begin
      if (fault_clear) state_d = S_OFF;
    end else if (!enable) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = pwm_q ? S_DT_TO_HS : S_DT_TO_LS;
          cnt_d   = dt_load;
        end
        S_HS_ON: begin
          if (!pwm_q) begin
            state_d = S_DT_TO_LS;
            cnt_d   = dt_load;
          end
        end
        S_LS_ON: begin
          if (pwm_q) begin
            state_d = S_DT_TO_HS;
            cnt_d   = dt_load;
          end
        end
        // An abort returns straight to the side that is already safe.
        S_DT_TO_HS: begin
          if (!pwm_q)              state_d = S_LS_ON;
          else if (cnt_q == '0)    state_d = S_HS_ON;
          else                     cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        S_DT_TO_LS: begin
          if (pwm_q)               state_d = S_HS_ON;
          else if (cnt_q == '0)    state_d = S_LS_ON;
          else                     cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_OFF;
      cnt_q         <= '0;
      pwm_q         <= 1'b0;
      hs_out        <= 1'b0;
      ls_out        <= 1'b0;
      dt_active     <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_in;
      hs_out        <= (state_d == S_HS_ON);
      ls_out        <= (state_d == S_LS_ON);
      dt_active     <= (state_d == S_DT_TO_HS) || (state_d == S_DT_TO_LS);
      fault_latched <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_inserter.sv
// Directed self-checking bench for pwm_deadtime_inserter; output vectors
// are compared as {hs_out, ls_out, dt_active, fault_latched}.
module tb_pwm_deadtime_inserter;

  localparam int DT_WIDTH = 8;

  logic                clk;
  logic                reset;
  logic                enable;
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dead_time;
  logic                fault;
  logic                fault_clear;
  logic                hs_out;
  logic                ls_out;
  logic                dt_active;
  logic                fault_latched;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;

  pwm_deadtime_inserter #(.DT_WIDTH(DT_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .dead_time    (dead_time),
    .fault        (fault),
    .fault_clear  (fault_clear),
    .hs_out       (hs_out),
    .ls_out       (ls_out),
    .dt_active    (dt_active),
    .fault_latched(fault_latched)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(negedge clk) begin
    if (hs_out === 1'b1 && ls_out === 1'b1) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {hs_out, ls_out, dt_active, fault_latched};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed hs/ls/dt/flt=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts dead cycles starting from a sample that is already in a dead interval.
  task automatic measure_gap(output int n);
    n = 0;
    while (dt_active === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int gap;
    int hs_cnt, ls_cnt, dt_cnt;
    logic hs_seen;

    reset       = 1'b0;
    enable      = 1'b0;
    pwm_in      = 1'b0;
    dead_time   = 8'd5;
    fault       = 1'b0;
    fault_clear = 1'b0;

    // Reset, then asynchronous reset in the middle of a dead interval
    tick();
    tick();
    check("reset_hold", 4'b0000);
    reset = 1'b1;
    tick();
    check("off_idle", 4'b0000);
    pwm_in = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    check("dt_to_hs_entry", 4'b0010);
    tick();
    #5;
    reset = 1'b0;
    #1;
    check("async_reset", 4'b0000);
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("off_after_reset", 4'b0000);

    // Start-up into LS_ON with dead_time=5
    pwm_in = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check("startup_dt_ls", 4'b0010);
    measure_gap(gap);
    check_int("startup_gap", gap, 5);
    check("startup_ls_on", 4'b0100);

    // Steady PWM: 50 high / 50 low, two periods
    hs_cnt = 0;
    ls_cnt = 0;
    dt_cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      pwm_in = (((i - 1) / 50) % 2 == 0);
      tick();
      if (i <= 100 && hs_out === 1'b1) hs_cnt++;
      if (i >= 52 && i <= 151 && ls_out === 1'b1) ls_cnt++;
      if (i <= 100 && dt_active === 1'b1) dt_cnt++;
      if (i == 1)  check("steady_ls_hold", 4'b0100);
      if (i == 2)  check("steady_ls_drop", 4'b0010);
      if (i == 6)  check("steady_dt_last", 4'b0010);
      if (i == 7)  check("steady_hs_rise", 4'b1000);
      if (i == 52) check("steady_hs_drop", 4'b0010);
      if (i == 57) check("steady_ls_rise", 4'b0100);
    end
    check_int("steady_hs_len", hs_cnt, 45);
    check_int("steady_ls_len", ls_cnt, 45);
    check_int("steady_dt_cycles", dt_cnt, 10);

    // dead_time=0 gives a single dead cycle each way
    dead_time = 8'd0;
    pwm_in = 1'b1;
    tick();
    check("dt0_capture", 4'b0100);
    tick();
    check("dt0_gap_hs", 4'b0010);
    tick();
    check("dt0_hs_on", 4'b1000);
    pwm_in = 1'b0;
    tick();
    check("dt0_capture_lo", 4'b1000);
    tick();
    check("dt0_gap_ls", 4'b0010);
    tick();
    check("dt0_ls_on", 4'b0100);

    // Changing dead_time mid-interval affects only the next interval
    dead_time = 8'd5;
    pwm_in = 1'b1;
    tick();
    tick();
    dead_time = 8'd10;
    measure_gap(gap);
    check_int("gap_before_change", gap, 5);
    check("hs_after_gap5", 4'b1000);
    pwm_in = 1'b0;
    tick();
    tick();
    measure_gap(gap);
    check_int("gap_after_change", gap, 10);
    check("ls_after_gap10", 4'b0100);

    // Short 3-cycle pulse with dead_time=8 aborts back to the low side
    dead_time = 8'd8;
    hs_seen = 1'b0;
    pwm_in = 1'b1;
    tick();
    hs_seen |= hs_out;
    check("short_capture", 4'b0100);
    tick();
    hs_seen |= hs_out;
    check("short_dt", 4'b0010);
    tick();
    hs_seen |= hs_out;
    pwm_in = 1'b0;
    tick();
    hs_seen |= hs_out;
    check("short_dt_hold", 4'b0010);
    tick();
    hs_seen |= hs_out;
    check("short_ls_return", 4'b0100);
    tick();
    hs_seen |= hs_out;
    check_int("short_hs_never", int'(hs_seen), 0);

    // Fault from HS_ON, clear ignored while fault held, restart after clear
    dead_time = 8'd2;
    pwm_in = 1'b1;
    tick();
    tick();
    measure_gap(gap);
    check_int("pre_fault_gap", gap, 2);
    check("hs_before_fault", 4'b1000);
    fault = 1'b1;
    tick();
    check("fault_entry", 4'b0001);
    fault_clear = 1'b1;
    tick();
    check("clear_while_fault", 4'b0001);
    fault = 1'b0;
    fault_clear = 1'b0;
    tick();
    check("fault_latched_hold", 4'b0001);
    fault_clear = 1'b1;
    tick();
    check("fault_cleared_off", 4'b0000);
    fault_clear = 1'b0;
    tick();
    check("restart_dt", 4'b0010);
    measure_gap(gap);
    check_int("restart_gap", gap, 2);
    check("hs_after_clear", 4'b1000);

    // Enable dropped in LS_ON, re-enabled with pwm high
    pwm_in = 1'b0;
    tick();
    tick();
    measure_gap(gap);
    check_int("to_ls_gap", gap, 2);
    check("ls_before_disable", 4'b0100);
    dead_time = 8'd3;
    enable = 1'b0;
    tick();
    check("enable_off", 4'b0000);
    pwm_in = 1'b1;
    tick();
    check("disabled_holds_off", 4'b0000);
    enable = 1'b1;
    tick();
    check("reenable_dt", 4'b0010);
    measure_gap(gap);
    check_int("reenable_gap", gap, 3);
    check("hs_after_enable", 4'b1000);

    check_int("no_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
